// File: rtl/counter_structural_pkg.sv
// Shared constants for the structural toggle-flop counter.
// Optional terminal-count output is enabled with COUNTER_STRUCTURAL_TC_EN.
package counter_structural_pkg;

   localparam int CNT_WIDTH_DEFAULT = 8;

   // Per-bit reset value; every stage of the chain clears to the same level.
   localparam bit CNT_RESET_VALUE = '0;

endpackage

// File: rtl/counter_structural_t_ff.sv
// Toggle flip-flop with asynchronous active-low clear.
// One instance per bit of counter_structural.
module t_ff
   import counter_structural_pkg::*;
(
   input  logic clk,
   input  logic clear,
   input  logic t,
   output logic q
);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         q <= CNT_RESET_VALUE;
      end else begin
         q <= q ^ t;
      end
   end

endmodule

// File: rtl/counter_structural.sv
// Free-running up-counter built from t_ff stages with a synchronous AND carry chain.
// Define COUNTER_STRUCTURAL_TC_EN to add the terminal-count output tc.
module counter_structural
   import counter_structural_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             clear,
`ifdef COUNTER_STRUCTURAL_TC_EN
   output logic             tc,
`endif
   output logic [WIDTH-1:0] q
);

   // t_chain[i] is high when every lower bit is 1, i.e. bit i must toggle.
   logic [WIDTH-1:0] t_chain;

   assign t_chain[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign t_chain[gi] = t_chain[gi-1] & q[gi-1];
      end

      for (gi = 0; gi < WIDTH; gi++) begin : g_stage
         t_ff u_t_ff (
            .clk   (clk),
            .clear (clear),
            .t     (t_chain[gi]),
            .q     (q[gi])
         );
      end
   endgenerate

`ifdef COUNTER_STRUCTURAL_TC_EN
   assign tc = &q;
`endif

endmodule

// File: tb/tb_counter_structural.sv
// Self-checking bench for counter_structural (WIDTH=8, 10 ns clock).
// Directed reset/wrap/release cases followed by randomized clear activity.
module tb_counter_structural;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         clear;
   logic [W-1:0] q;
`ifdef COUNTER_STRUCTURAL_TC_EN
   logic         tc;
`endif

   int           n_tests = 0;
   int           n_fail  = 0;
   int           exp_cnt = 0;
   int           prev_exp;
   logic [W-1:0] prev_q;

   always #5 clk = ~clk;

   counter_structural #(.WIDTH(W)) dut (
      .clk   (clk),
      .clear (clear),
`ifdef COUNTER_STRUCTURAL_TC_EN
      .tc    (tc),
`endif
      .q     (q)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_out(input string tag);
      check_val(tag, 32'(q), 32'(exp_cnt));
`ifdef COUNTER_STRUCTURAL_TC_EN
      check_val({tag, "_tc"}, 32'(tc), (exp_cnt == MOD - 1) ? 32'd1 : 32'd0);
`endif
   endtask

   // Advance one rising edge; the model uses the clear level held before the edge.
   // rel_at_edge releases clear in the same time step as the edge; the
   // non-blocking update lands after the flops have sampled, so the edge still
   // sees clear low, which is the coincident-release case.
   task automatic tick(input bit rel_at_edge, input string tag);
      prev_exp = exp_cnt;
      prev_q   = q;
      @(posedge clk);
      exp_cnt = (clear === 1'b1) ? (exp_cnt + 1) % MOD : 0;
      if (rel_at_edge) clear <= 1'b1;
      #1;
      check_out(tag);
      check_val({tag, "_toggle"}, 32'(q ^ prev_q), 32'(prev_exp ^ exp_cnt));
      #3;
      check_val({tag, "_stable"}, 32'(q), 32'(exp_cnt));
   endtask

   // Called 4 ns after an edge: clear low now, release w ns later (before next edge).
   task automatic pulse(input int w, input string tag);
      clear   = 1'b0;
      exp_cnt = 0;
      #1;
      check_out({tag, "_async"});
      #(w);
      clear = 1'b1;
   endtask

   initial begin
      int r;
      int guard;

      clear = 1'b1;
      #1 clear = 1'b0;
      exp_cnt = 0;
      #1 check_out("reset_async");
      tick(1'b0, "reset_hold");
      #5 clear = 1'b1;          // 1 ns before the edge at 15 ns
      $display("[TB] reset checked, counting from release");

      for (int i = 0; i < 260; i++) tick(1'b0, "count");
      $display("[TB] 260 edges done, q=%0d", q);

      guard = 0;
      while (exp_cnt != 37 && guard < 300) begin
         tick(1'b0, "to37");
         guard++;
      end
      check_val("reach37", 32'(q), 32'd37);
      pulse(4, "mid_pulse");
      tick(1'b0, "after_pulse");
      $display("[TB] mid-count clear at 37 done, q=%0d", q);

      clear   = 1'b0;
      exp_cnt = 0;
      #1 check_out("coinc_async");
      tick(1'b1, "coinc_edge");
      tick(1'b0, "coinc_next");
      $display("[TB] coincident release done, q=%0d", q);

      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            pulse($urandom_range(1, 4), "rand_pulse");
         end else if (r < 7) begin
            clear   = 1'b0;
            exp_cnt = 0;
            #1 check_out("rand_hold_async");
            repeat ($urandom_range(1, 3)) tick(1'b0, "rand_hold");
            if ($urandom_range(0, 1) == 1) tick(1'b1, "rand_coinc");
            else #1 clear = 1'b1;
         end else begin
            tick(1'b0, "rand_count");
         end
      end
      $display("[TB] random phase done, q=%0d", q);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
